spi_peripheral: RTL and testbench

- SPI mode-0 target that sits directly upstream of the PWM generator inside tt_um_uwasic_onboarding_eva_jin.
- Oversamples SCLK/COPI/nCS (pins ui_in[0]/[1]/[2]) in the clk domain and decodes 16-bit write transactions.
- Drives the five configuration registers consumed by the PWM stage: output enables, PWM enables, duty cycle.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_peripheral_sync_edge.sv | 34 +++
 rtl/spi_peripheral.sv | 173 +++++++++++++++++
 tb/tb_spi_peripheral.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and FSM state type for the SPI register target.
package spi_pkg;

  localparam int TXN_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } spi_state_t;

endpackage

// File: rtl/spi_peripheral_sync_edge.sv
// sync_edge: multi-flop synchronizer for one async pin plus a history flop
// that yields single-cycle rise/fall strobes in the clk domain.
module sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = o_sync & ~r_hist;
  assign o_fall = ~o_sync & r_hist;

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 write target feeding the PWM config registers.
// Define SPI_READBACK_EN to add register readback on cipo.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TXN_BITS    = spi_pkg::TXN_BITS,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done
);

  localparam int CW = $clog2(TXN_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(TXN_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TXN_BITS + 1);

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_copi_sync, w_copi_rise, w_copi_fall;
  logic w_ncs_sync, w_ncs_rise, w_ncs_fall;
  logic w_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(sclk),
    .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst_n(rst_n), .i_d(copi),
    .o_sync(w_copi_sync), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst_n(rst_n), .i_d(ncs),
    .o_sync(w_ncs_sync), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  assign w_unused = ^{w_sclk_sync, w_sclk_fall, w_copi_rise, w_copi_fall};

  spi_state_t r_state, w_state_n;
  logic [TXN_BITS-1:0] r_shift;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf;
  logic                r_txn_done;
  logic [7:0] r_en_out_lo, r_en_out_hi;
  logic [7:0] r_en_pwm_lo, r_en_pwm_hi, r_duty;

  logic       w_rw;
  logic [6:0] w_addr;
  logic [7:0] w_data;
  logic       w_commit;

  assign w_rw   = r_shift[TXN_BITS-1];
  assign w_addr = r_shift[TXN_BITS-2 -: 7];
  assign w_data = r_shift[7:0];

  assign w_commit = (r_state == COMMIT) && (r_cnt == CNT_FULL) &&
                    !r_ovf && w_rw && (w_addr <= 7'(MAX_ADDR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (w_ncs_fall) w_state_n = SHIFT;
      SHIFT:   if (w_ncs_rise) w_state_n = COMMIT;
      COMMIT:  w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_txn_done  <= 1'b0;
      r_en_out_lo <= 8'h00;
      r_en_out_hi <= 8'h00;
      r_en_pwm_lo <= 8'h00;
      r_en_pwm_hi <= 8'h00;
      r_duty      <= 8'h00;
    end else begin
      r_txn_done <= 1'b0;
      if (r_state == IDLE && w_ncs_fall) begin
        r_shift <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end
      // Counter saturates one past a full frame so long frames stay rejected
      if (r_state == SHIFT && w_sclk_rise && !w_ncs_sync &&
          r_cnt != CNT_MAX) begin
        r_shift <= {r_shift[TXN_BITS-2:0], w_copi_sync};
        r_cnt   <= r_cnt + 1'b1;
        if (r_cnt == CNT_FULL) r_ovf <= 1'b1;
      end
      if (w_commit) begin
        r_txn_done <= 1'b1;
        case (w_addr)
          ADDR_EN_OUT_LO: r_en_out_lo <= w_data;
          ADDR_EN_OUT_HI: r_en_out_hi <= w_data;
          ADDR_EN_PWM_LO: r_en_pwm_lo <= w_data;
          ADDR_EN_PWM_HI: r_en_pwm_hi <= w_data;
          ADDR_DUTY:      r_duty      <= w_data;
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = r_en_out_lo;
  assign en_reg_out_15_8 = r_en_out_hi;
  assign en_reg_pwm_7_0  = r_en_pwm_lo;
  assign en_reg_pwm_15_8 = r_en_pwm_hi;
  assign pwm_duty_cycle  = r_duty;
  assign txn_done        = r_txn_done;

`ifdef SPI_READBACK_EN
  logic [3:0] r_fall_cnt;
  logic [7:0] r_rd_sr;
  logic [7:0] w_rd_data;
  logic       w_rd_ok;

  assign w_rd_ok = !r_shift[7] && (r_shift[6:0] <= 7'(MAX_ADDR));

  always_comb begin
    w_rd_data = 8'h00;
    case (r_shift[6:0])
      ADDR_EN_OUT_LO: w_rd_data = r_en_out_lo;
      ADDR_EN_OUT_HI: w_rd_data = r_en_out_hi;
      ADDR_EN_PWM_LO: w_rd_data = r_en_pwm_lo;
      ADDR_EN_PWM_HI: w_rd_data = r_en_pwm_hi;
      ADDR_DUTY:      w_rd_data = r_duty;
      default:        w_rd_data = 8'h00;
    endcase
  end

  // Header byte is complete at the 8th fall; data leaves MSB first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fall_cnt <= '0;
      r_rd_sr    <= 8'h00;
    end else if (w_ncs_rise || r_state != SHIFT) begin
      r_fall_cnt <= '0;
      r_rd_sr    <= 8'h00;
    end else if (w_sclk_fall && !w_ncs_sync) begin
      if (r_fall_cnt != 4'hF) r_fall_cnt <= r_fall_cnt + 1'b1;
      if (r_fall_cnt == 4'd7)
        r_rd_sr <= w_rd_ok ? w_rd_data : 8'h00;
      else
        r_rd_sr <= {r_rd_sr[6:0], 1'b0};
    end
  end

  assign cipo = r_rd_sr[7];
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed SPI frames with a commit scoreboard and
// cycle-exact latency checks on the register outputs and txn_done.
module tb_spi_peripheral;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n, sclk, copi, ncs;
  logic cipo, txn_done;
  logic [7:0] r0, r1, r2, r3, r4;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    bit         commit;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m[5];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_done = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (txn_done === 1'b1) n_done++;

  spi_peripheral #(.SYNC_STAGES(SYNC), .TXN_BITS(16), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1),
    .en_reg_pwm_7_0(r2), .en_reg_pwm_15_8(r3),
    .pwm_duty_cycle(r4), .txn_done(txn_done)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dut_reg(input int a);
    case (a)
      0: return r0;
      1: return r1;
      2: return r2;
      3: return r3;
      default: return r4;
    endcase
  endfunction

  task automatic chk_regs(input string tag);
    for (int a = 0; a < 5; a++)
      chk($sformatf("%s.reg%0d", tag, a), 32'(dut_reg(a)), 32'(m[a]));
  endtask

  // Drive one frame; when raise is set, check timing around the commit.
  task automatic frame(input string tag, input int nbits,
                       input logic [15:0] w, input bit raise,
                       output logic [7:0] rd);
    exp_t e;
    int   d0;
    rd = 8'h00;
    d0 = n_done;
    if (raise) begin
      e.addr   = w[14:8];
      e.data   = w[7:0];
      e.commit = (nbits == 16) && w[15] && (w[14:8] <= 7'd4);
      q.push_back(e);
    end
    ncs = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? w[15-i] : 1'b0;
      tick(HALF);
      if (i >= 8 && i < 16) rd = {rd[6:0], cipo};
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    if (!raise) return;
    ncs = 1'b1;
    tick(SYNC + 1);
    chk({tag, ".done_early"}, 32'(txn_done), 32'(0));
    chk_regs({tag, ".pre"});
    tick(1);
    e = q.pop_front();
    if (e.commit) m[e.addr] = e.data;
    chk({tag, ".done"}, 32'(txn_done), 32'(e.commit));
    chk_regs({tag, ".post"});
    chk({tag, ".cipo_idle"}, 32'(cipo), 32'(0));
    tick(1);
    chk({tag, ".done_drop"}, 32'(txn_done), 32'(0));
    chk({tag, ".pulses"}, 32'(n_done - d0), 32'(e.commit));
    tick(4);
  endtask

  initial begin
    logic [7:0] rd;
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    for (int a = 0; a < 5; a++) m[a] = 8'h00;
    tick(4);
    rst_n = 1'b1;
    tick(4);
    chk_regs("reset");
    chk("reset.done", 32'(txn_done), 32'(0));
    chk("reset.cipo", 32'(cipo), 32'(0));

    frame("wr0", 16, 16'h80F0, 1'b1, rd);
    frame("wr4", 16, 16'h8480, 1'b1, rd);
    frame("wr2", 16, 16'h82FF, 1'b1, rd);
    frame("badaddr", 16, 16'hB0AA, 1'b1, rd);
    frame("short", 15, 16'h8155, 1'b1, rd);
    frame("long", 17, 16'h8155, 1'b1, rd);
    frame("wr1", 16, 16'h8155, 1'b1, rd);

    frame("partial", 9, 16'h803C, 1'b0, rd);
    rst_n = 1'b0;
    ncs   = 1'b1;
    tick(3);
    for (int a = 0; a < 5; a++) m[a] = 8'h00;
    rst_n = 1'b1;
    tick(6);
    chk_regs("midreset");
    chk("midreset.done", 32'(txn_done), 32'(0));
    frame("wr0b", 16, 16'h803C, 1'b1, rd);

    frame("wr4b", 16, 16'h8480, 1'b1, rd);
    frame("rd4", 16, 16'h0400, 1'b1, rd);
`ifdef SPI_READBACK_EN
    chk("rd4.cipo", 32'(rd), 32'(8'h80));
`else
    chk("rd4.cipo", 32'(rd), 32'(8'h00));
`endif
    chk("queue_empty", 32'(q.size()), 32'(0));
    chk("total_pulses", 32'(n_done), 32'(6));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
